// File: rtl/uart_frame_decoder_pkg.sv
// Shared types and constants for the UART command-frame decoder.
// Also holds the command codes that the game control logic uses.
package uart_frame_decoder_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned GAP_W  = 20;

    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'h55;
    localparam logic [BYTE_W-1:0] ERR_MAX      = 8'hFF;

    localparam logic [BYTE_W-1:0] CMD_P1_PADDLE = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_P2_PADDLE = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_SERVE     = 8'h10;
    localparam logic [BYTE_W-1:0] CMD_PAUSE     = 8'h20;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        GET_CMD   = 2'd1,
        GET_DATA  = 2'd2,
        GET_CSUM  = 2'd3
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] code;
        logic [BYTE_W-1:0] data;
    } cmd_t;

    function automatic logic [BYTE_W-1:0] frame_csum(input cmd_t c);
        return c.code ^ c.data;
    endfunction

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-in / command-out bundle between the receiver, the decoder and game logic.
interface uart_frame_decoder_if
    import uart_frame_decoder_pkg::*;
();
    logic              data_valid;
    logic [BYTE_W-1:0] data_byte_in;
    logic              cmd_valid;
    logic [BYTE_W-1:0] cmd_code;
    logic [BYTE_W-1:0] cmd_data;
    logic              frame_err;
    logic [BYTE_W-1:0] err_count;

    modport master (
        output data_valid, data_byte_in,
        input  cmd_valid, cmd_code, cmd_data, frame_err, err_count
    );

    modport slave (
        input  data_valid, data_byte_in,
        output cmd_valid, cmd_code, cmd_data, frame_err, err_count
    );
endinterface

// File: rtl/frame_gap_timer.sv
// Inter-byte gap counter; expired_c flags the last allowed idle clock of a frame.
module frame_gap_timer #(
    parameter int unsigned width = 20,
    parameter int unsigned limit = 100000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam logic [width-1:0] LAST = width'(limit - 1);

    logic [width-1:0] count_q;

    assign expired_c = enable && (count_q == LAST);

    // Clear wins over counting; the count parks at LAST until cleared.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired_c) begin
            count_q <= count_q + width'(1);
        end
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles sync/cmd/data/checksum frames from the UART byte stream and
// issues a command strobe per good frame; bad or stalled frames are counted.
module uart_frame_decoder
    import uart_frame_decoder_pkg::*;
#(
    parameter logic [BYTE_W-1:0] sync_byte    = SYNC_DEFAULT,
    parameter int unsigned       timeout_clks = 100000
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    uart_frame_decoder_if.slave  bus
);

    state_e            state_q, state_d;
    cmd_t              frame_q, frame_d;
    cmd_t              cmd_out_q, cmd_out_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [BYTE_W-1:0] err_count_q, err_count_d;
    logic              gap_expired_c;

    frame_gap_timer #(
        .width (GAP_W),
        .limit (timeout_clks)
    ) u_gap_timer (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .clear     (bus.data_valid),
        .enable    (state_q != WAIT_SYNC),
        .expired_c (gap_expired_c)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_SYNC;
            frame_q     <= '0;
            cmd_out_q   <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            cmd_out_q   <= cmd_out_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        cmd_out_d   = cmd_out_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            WAIT_SYNC: begin
                if (bus.data_valid && (bus.data_byte_in == sync_byte)) begin
                    state_d = GET_CMD;
                end
            end
            GET_CMD: begin
                if (bus.data_valid) begin
                    frame_d.code = bus.data_byte_in;
                    state_d      = GET_DATA;
                end
            end
            GET_DATA: begin
                if (bus.data_valid) begin
                    frame_d.data = bus.data_byte_in;
                    state_d      = GET_CSUM;
                end
            end
            GET_CSUM: begin
                if (bus.data_valid) begin
                    if (bus.data_byte_in == frame_csum(frame_q)) begin
                        cmd_out_d   = frame_q;
                        cmd_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = WAIT_SYNC;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase

        // A byte on the expiry cycle is processed instead of timing out.
        if (!bus.data_valid && gap_expired_c) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_SYNC;
        end

        err_count_d = err_count_q;
        if (frame_err_d && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + BYTE_W'(1);
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_code  = cmd_out_q.code;
    assign bus.cmd_data  = cmd_out_q.data;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_count_q;

endmodule
